product_bcd_converter: RTL and testbench
========================================

// Module: product_bcd_converter
// PURPOSE
//   Sequential binary-to-BCD converter downstream of the multiplier.
//   Captures a signed product (magnitude word plus sign flag) on a start strobe.
//   Converts the magnitude with the shift-add-3 (double-dabble) algorithm, one bit per clock.
//   Holds sign-magnitude BCD digits stable for the display / output stage.
// PARAMETERS
//   WORD_LENGTH  16  width of the Result input (product word)
//   DIGITS       5   number of BCD digits; must satisfy 10**DIGITS > 2**WORD_LENGTH - 1
// PORTS
//   clk       in   1               system clock, rising edge
//   reset     in   1               asynchronous, active-low reset
//   start     in   1               request conversion; sampled only in IDLE
//   Result    in   WORD_LENGTH     product word
//   Sign      in   1               1: Result is two's-complement negative; 0: unsigned positive
//   busy      out  1               conversion in progress (SHIFT or DONE)
//   ready     out  1               one-cycle pulse: BCD/Sign_out just updated
//   Sign_out  out  1               sign of the last converted value
//   BCD       out  4*DIGITS        packed digits, [3:0] = units, MSD at top
// BEHAVIOUR
//   Reset (reset=0, async): state=IDLE; busy=0; ready=0; Sign_out=0; BCD=0; all scratch regs 0.
//   States: IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE:
//     - start=1 at edge E0 -> capture mag_r, sign_r=Sign, scratch=0, cnt=0; go SHIFT.
//     - mag_r = Sign ? (~Result + 1) mod 2**WORD_LENGTH : Result.
//     - With Sign=1, Result=2**(WORD_LENGTH-1) gives magnitude 2**(WORD_LENGTH-1), unsigned and correct.
//   SHIFT: each edge, in this order:
//     - every scratch digit >= 5 gets +3;
//     - {scratch,mag_r} shifts left by 1;
//     - cnt++.
//     - After WORD_LENGTH shifts (cnt reaches WORD_LENGTH-1 at that edge), go DONE.
//   DONE:
//     - edge E0+WORD_LENGTH+1 loads BCD<=scratch, Sign_out<=sign_r, ready<=1; go IDLE.
//     - ready is registered: high exactly one cycle after that edge, then 0.
//   Latency: ready rises WORD_LENGTH+1 edges after the start-sampling edge (17 for defaults).
//     - Next start is accepted at the edge ready is high (back-to-back allowed).
//   busy: 1 from edge E0 until the edge that sets ready; 0 while ready is high.
//   start while busy=1: ignored; captured inputs and outputs are unaffected. No queueing.
//   Result/Sign may change freely after E0; only the value sampled at E0 is used.
//   BCD and Sign_out change only on the ready edge (or reset) and otherwise hold.
//   Zero magnitude: Sign_out = sign_r as captured. Sign=1 with Result=0 gives Sign_out=1, BCD=0 (no -0 fixup).
//   Reset mid-conversion: immediate return to IDLE, outputs zeroed, no ready pulse.
//   Digit values in BCD are always 0..9.
//   cnt is $clog2(WORD_LENGTH)+1 bits wide and never wraps.
// TESTING
//   - Reset low then high, no start -> BCD=0, Sign_out=0, busy=0, ready never asserts.
//   - Result=16'd12345, Sign=0, start 1 cycle -> 17 edges later ready=1, BCD=20'h12345, Sign_out=0.
//   - Result=16'hFFFF, Sign=1 -> BCD=20'h00001, Sign_out=1.
//     Result=16'h8000, Sign=1 -> BCD=20'h32768, Sign_out=1.
//   - Result=16'hFFFF, Sign=0 -> BCD=20'h65535; then start again on the ready cycle with 16'd0
//     -> BCD=20'h00000 exactly 17 edges later.
//   - start pulsed at cycle 5 of a conversion with different Result -> ignored.
//     The first result is delivered unchanged; only one ready pulse.
//   - reset asserted at cycle 8 of a conversion -> outputs 0 immediately; no ready.
//     A new start after release converts correctly.

Source files
------------

// File: rtl/product_bcd_converter.sv
// product_bcd_converter
// Sequential binary-to-BCD converter for the signed multiplier product.
// A start strobe captures the magnitude and sign. The magnitude is then converted
// by shift-add-3 (double dabble), one bit per clock. Sign-magnitude BCD digits are
// held stable for the display stage.
//
// Handshake: start is sampled only while the FSM is IDLE (busy=0). It is ignored
// at every other time, and starts are never queued. ready is a one-cycle registered
// pulse that marks a new BCD/Sign_out value. A start presented during that ready
// cycle is accepted, which allows back-to-back conversions.
module product_bcd_converter #(
   parameter int WORD_LENGTH = 16,
   parameter int DIGITS      = 5
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [WORD_LENGTH-1:0]  Result,
   input  logic                    Sign,
   output logic                    busy,
   output logic                    ready,
   output logic                    Sign_out,
   output logic [4*DIGITS-1:0]     BCD,
   output logic [1:0]              state_dbg
);

   localparam int CNT_W = $clog2(WORD_LENGTH) + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t                   state, state_nxt;
   logic [WORD_LENGTH-1:0]   mag_r;
   logic                     sign_r;
   logic [4*DIGITS-1:0]      scratch;
   logic [4*DIGITS-1:0]      scratch_adj;
   logic [CNT_W-1:0]         cnt;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode: one SHIFT cycle per magnitude bit, then one DONE cycle
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SHIFT;
         SHIFT:   if (cnt == CNT_W'(WORD_LENGTH - 1)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Add 3 to every BCD digit >= 5, so the following shift carries correctly
   always_comb begin
      scratch_adj = scratch;
      for (int i = 0; i < DIGITS; i++) begin
         if (scratch[4*i +: 4] >= 4'd5)
            scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
   end

   // Datapath: capture on start, shift during SHIFT, publish on DONE
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mag_r    <= '0;
         sign_r   <= 1'b0;
         scratch  <= '0;
         cnt      <= '0;
         BCD      <= '0;
         Sign_out <= 1'b0;
         ready    <= 1'b0;
      end else begin
         ready <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  // Two's-complement negate. The most negative word maps onto its own bit
                  // pattern, which is the correct unsigned magnitude.
                  mag_r   <= Sign ? (~Result + 1'b1) : Result;
                  sign_r  <= Sign;
                  scratch <= '0;
                  cnt     <= '0;
               end
            end
            SHIFT: begin
               {scratch, mag_r} <= {scratch_adj, mag_r} << 1;
               cnt              <= cnt + 1'b1;
            end
            DONE: begin
               BCD      <= scratch;
               Sign_out <= sign_r;
               ready    <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy      = (state != IDLE);
   assign state_dbg = state;

endmodule

// File: tb/tb_product_bcd_converter.sv
// Testbench for product_bcd_converter: scoreboard of expected {sign, BCD} results
// plus the expected ready edge for each accepted start.
module tb_product_bcd_converter;

   logic        clk;
   logic        reset;
   logic        start;
   logic [15:0] Result;
   logic        Sign;
   logic        busy;
   logic        ready;
   logic        Sign_out;
   logic [19:0] BCD;
   logic [1:0]  state_dbg;

   int n_cmp = 0;
   int n_err = 0;
   int edge_cnt = 0;

   logic [20:0] exp_q[$];
   int          lat_q[$];

   product_bcd_converter dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .Result    (Result),
      .Sign      (Sign),
      .busy      (busy),
      .ready     (ready),
      .Sign_out  (Sign_out),
      .BCD       (BCD),
      .state_dbg (state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference: decimal digits computed by repeated division
   function automatic logic [20:0] model(input logic [15:0] r, input logic s);
      int          m;
      logic [19:0] d;
      m = s ? ((65536 - int'(r)) % 65536) : int'(r);
      d = '0;
      for (int i = 0; i < 5; i++) begin
         d[4*i +: 4] = 4'(m % 10);
         m = m / 10;
      end
      return {s, d};
   endfunction

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      logic [20:0] e;
      int          l;
      if (reset && ready) begin
         if (exp_q.size() == 0) begin
            check("extra_ready", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            l = lat_q.pop_front();
            check("bcd", 32'(BCD), 32'(e[19:0]));
            check("sign_out", 32'(Sign_out), 32'(e[20]));
            check("latency", 32'(edge_cnt), 32'(l));
            check("busy_at_ready", 32'(busy), 32'd0);
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Assert start now; it is sampled at the next rising edge.
   task automatic start_now(input logic [15:0] r, input logic s, input bit expect_result);
      start  = 1'b1;
      Result = r;
      Sign   = s;
      if (expect_result) begin
         exp_q.push_back(model(r, s));
         lat_q.push_back(edge_cnt + 1 + 17);
      end
   endtask

   // After the sampling edge, drop start and scramble the inputs.
   task automatic end_start();
      @(posedge clk);
      #1;
      start  = 1'b0;
      Result = 16'($urandom_range(0, 65535));
      Sign   = 1'($urandom_range(0, 1));
   endtask

   task automatic convert(input logic [15:0] r, input logic s);
      @(posedge clk);
      #1;
      start_now(r, s, 1'b1);
      end_start();
   endtask

   task automatic wait_drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic wait_ready();
      int t = 0;
      @(negedge clk);
      while (!ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!ready) check("ready_timeout", 32'd0, 32'd1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [19:0] held;
      reset  = 1'b0;
      start  = 1'b0;
      Result = '0;
      Sign   = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;

      // Idle after reset: zeroed outputs, no ready
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("rst_ready", 32'(ready), 32'd0);
      end
      check("rst_bcd", 32'(BCD), 32'd0);
      check("rst_sign", 32'(Sign_out), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_state", 32'(state_dbg), 32'd0);

      // Directed values
      convert(16'd12345, 1'b0);
      @(negedge clk);
      check("busy_running", 32'(busy), 32'd1);
      wait_drain();
      convert(16'hFFFF, 1'b1);
      wait_drain();
      convert(16'h8000, 1'b1);
      wait_drain();
      convert(16'd0, 1'b1);
      wait_drain();

      // Back-to-back: a new start on the ready cycle
      convert(16'hFFFF, 1'b0);
      wait_ready();
      start_now(16'd0, 1'b0, 1'b1);
      end_start();
      wait_drain();

      // Start while busy is ignored
      convert(16'd4321, 1'b0);
      repeat (4) @(posedge clk);
      #1 start_now(16'd999, 1'b1, 1'b0);
      end_start();
      wait_drain();
      repeat (25) @(negedge clk);
      check("hold_bcd", 32'(BCD), 32'h04321);

      // Reset in the middle of a conversion
      convert(16'd777, 1'b1);
      exp_q.delete();
      lat_q.delete();
      repeat (7) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      check("midrst_bcd", 32'(BCD), 32'd0);
      check("midrst_sign", 32'(Sign_out), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_ready", 32'(ready), 32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      repeat (25) @(negedge clk);
      check("post_rst_bcd", 32'(BCD), 32'd0);
      convert(16'd2024, 1'b0);
      wait_drain();

      // Random values
      for (int i = 0; i < 8; i++) begin
         convert(16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
         wait_drain();
      end

      // Held value is stable without a start
      held = BCD;
      repeat (20) @(negedge clk);
      check("final_hold", 32'(BCD), 32'(held));
      check("final_ready", 32'(ready), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
